encoder_nbits_pipe: RTL and testbench
=====================================

ENCODER_NBITS_PIPE -- requirements
Module: encoder_nbits_pipe

Interface
REQ-001 Parameter WIDTH, default 8: number of input request bits; legal range 2..64.
REQ-002 Parameter MODE, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin priority.
REQ-003 Derived constant OUT_W = ceil(log2(WIDTH)): code width; 3 at default.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data is presented.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  request vector; any bit pattern is legal.
REQ-009 out_valid  output  1  out_* result fields are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_code  output  OUT_W  index of the granted bit.
REQ-012 out_onehot  output  1  the accepted vector had exactly one bit set.
REQ-013 out_zero  output  1  the accepted vector was all zero.
REQ-014 err_cnt  output  8  count of non-one-hot accepted vectors; present only under ENC_ERR_CNT_EN.

Function
REQ-015 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready (combinational; one-entry output register).
REQ-017 Latency: an accepted vector's result appears on out_* with out_valid=1 exactly one cycle after acceptance.
REQ-018 Output state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 EMPTY -> FULL on transfer in.
REQ-020 FULL -> EMPTY on transfer out with no transfer in.
REQ-021 FULL stays FULL on simultaneous transfer out and transfer in; out_* loads the new result with no bubble.
REQ-022 While FULL and out_ready=0: out_* holds stable, in_ready=0, and in_data is not sampled.
REQ-023 MODE 0: out_code = index of the lowest set bit of in_data.
REQ-024 MODE 1: search starts at pointer ptr and ascends modulo WIDTH; out_code = the first set index found.
REQ-025 MODE 1: after a transfer in with nonzero data, ptr <= (granted index + 1) mod WIDTH, wrapping WIDTH-1 -> 0 for any WIDTH, including non-power-of-2.
REQ-026 Zero input: out_code=0, out_zero=1, out_onehot=0; ptr unchanged.
REQ-027 Multi-hot input: the code follows REQ-023/REQ-024; out_onehot=0.
REQ-028 One-hot input: out_onehot=1, and out_code equals the set bit's index in both modes.

Reset
REQ-029 reset asserted: out_valid=0, out_code=0, out_onehot=0, out_zero=0, ptr=0, err_cnt=0 at the next edge.
REQ-030 reset takes priority over any simultaneous transfer; a result in flight is discarded.
REQ-031 During reset, in_ready=1.

Configuration
REQ-032 Macro ENC_ERR_CNT_EN defined: err_cnt increments on each transfer in whose vector is not one-hot (zero or multi-hot) and saturates at 255.
REQ-033 Macro ENC_ERR_CNT_EN undefined: the err_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-034 Package enc_pkg holds MODE_FIXED=0, MODE_RR=1, and a clog2 function used to derive OUT_W.
REQ-035 Sub-module enc_prio_core performs the combinational search.
REQ-036 enc_prio_core inputs: vector and start index; outputs: code, onehot, zero.
REQ-037 encoder_nbits_pipe instantiates enc_prio_core once and holds all registers.

Verification
REQ-038 WIDTH=8, MODE 0: in_data=8'b0001_0000 accepted -> next cycle out_code=4, out_onehot=1, out_zero=0, err_cnt=0.
REQ-039 WIDTH=8, MODE 0: in_data=8'b1010_0000 -> out_code=5, out_onehot=0, err_cnt=1; then 8'h00 -> out_code=0, out_zero=1, err_cnt=2.
REQ-040 WIDTH=8, MODE 1: 8'b1000_0001 sent three times -> out_code 0, 7, 0; WIDTH=5, MODE 1: 5'b10001 three times -> 0, 4, 0.
REQ-041 Backpressure: out_ready=0, inputs 8'h02 then 8'h40 -> out_code=1 held, in_ready=0; out_ready=1 for one cycle -> out_code=6 the next cycle, with no loss or duplication.
REQ-042 Streaming: in_valid=1 and out_ready=1 every cycle with 8'h01, 8'h02, 8'h04 -> out_code 0, 1, 2 on consecutive cycles, out_valid held at 1.
REQ-043 Reset mid-operation: FULL, MODE 1, ptr=3, err_cnt=5, reset pulsed -> out_valid=0, ptr=0, err_cnt=0; next 8'b1000_1000 -> out_code=3.

Source files
------------

// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the pipelined priority encoder:
//   MODE_FIXED / MODE_RR  - priority scheme selectors for the MODE parameter
//   out_state_e           - occupancy state of the one-entry output register
//   clog2()               - elaboration-time ceil(log2(n)) used to size codes
// No ports (package).
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // ceil(log2(value)) for value >= 2; a bounded loop keeps it usable in
  // constant expressions for parameter-derived widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/enc_prio_core.sv
// ---------------------------------------------------------------------------
// enc_prio_core
// Purely combinational search of a request vector. In fixed mode the lowest
// set index wins; in round-robin mode the search starts at start_i and
// ascends modulo WIDTH, so the first set bit at or after start_i wins.
// Ports:
//   vec_i    [WIDTH]  request vector
//   start_i  [OUT_W]  round-robin start index (ignored in fixed mode)
//   code_o   [OUT_W]  index of the granted bit (0 when vec_i is zero)
//   onehot_o          vec_i has exactly one bit set
//   zero_o            vec_i is all zero
// ---------------------------------------------------------------------------
module enc_prio_core
  import enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_FIXED,
  localparam int OUT_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [OUT_W-1:0] start_i,
  output logic [OUT_W-1:0] code_o,
  output logic             onehot_o,
  output logic             zero_o
);

  // Each set bit is ranked by its distance from the start index, measured
  // upward with wrap-around. The smallest distance wins, which is exactly
  // the first set bit met by an ascending modulo-WIDTH scan. In fixed mode
  // the start is pinned to 0, so the distance is just the bit index.
  always_comb begin
    int base;
    int off;
    int bestOff;
    base    = (MODE == MODE_RR) ? int'(start_i) : 0;
    off     = 0;
    bestOff = WIDTH;
    code_o  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      off = j - base;
      if (off < 0) begin
        off = off + WIDTH;
      end
      if (vec_i[j] && (off < bestOff)) begin
        bestOff = off;
        code_o  = OUT_W'(j);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  assign zero_o   = (vec_i == '0);
  assign onehot_o = !zero_o && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder_nbits_pipe.sv
// ---------------------------------------------------------------------------
// encoder_nbits_pipe
// Priority encoder with a valid/ready input and a one-entry registered output
// stage. Each accepted vector produces its result one cycle later; a full
// output register that is being drained can accept a new vector in the same
// cycle, so back-to-back streaming runs without bubbles.
// Parameters:
//   WIDTH  number of request bits (2..64)
//   MODE   MODE_FIXED (lowest index wins) or MODE_RR (round-robin pointer)
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid/in_ready input handshake, in_data [WIDTH] request vector
//   out_valid/out_ready output handshake
//   out_code [OUT_W]  granted index
//   out_onehot        accepted vector had exactly one bit set
//   out_zero          accepted vector was all zero
//   err_cnt [8]       saturating count of non-one-hot accepted vectors,
//                     present only when ENC_ERR_CNT_EN is defined
// ---------------------------------------------------------------------------
module encoder_nbits_pipe
  import enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_FIXED,
  localparam int OUT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_onehot,
  output logic             out_zero
`ifdef ENC_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  out_state_e       state_q;
  logic [OUT_W-1:0] code_q;
  logic             onehot_q;
  logic             zero_q;
  logic [OUT_W-1:0] ptr_q;
  logic [OUT_W-1:0] ptr_d;

  logic [OUT_W-1:0] coreCode;
  logic             coreOnehot;
  logic             coreZero;
  logic             xferIn;
  logic             xferOut;

  enc_prio_core #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_core (
    .vec_i    (in_data),
    .start_i  (ptr_q),
    .code_o   (coreCode),
    .onehot_o (coreOnehot),
    .zero_o   (coreZero)
  );

  // The output register can take a new result whenever it is empty or its
  // current content leaves this cycle. Reset also opens the input so the
  // upstream never sees a stall while the block is being cleared.
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = reset || !out_valid || out_ready;
  assign xferIn    = in_valid && in_ready;
  assign xferOut   = out_valid && out_ready;

  assign out_code   = code_q;
  assign out_onehot = onehot_q;
  assign out_zero   = zero_q;

  // Round-robin pointer advances past the granted index, wrapping explicitly
  // at WIDTH-1 so non-power-of-2 widths never land on an unused index.
  // Zero vectors grant nothing and leave the pointer where it was.
  always_comb begin
    ptr_d = ptr_q;
    if ((MODE == MODE_RR) && xferIn && !coreZero) begin
      if (coreCode == OUT_W'(WIDTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = coreCode + OUT_W'(1);
      end
    end
  end

  // Output state machine and result registers. A drain with a simultaneous
  // fill keeps the stage FULL and simply reloads the result fields. While
  // FULL and stalled nothing is accepted, so the fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      code_q   <= '0;
      onehot_q <= 1'b0;
      zero_q   <= 1'b0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xferIn) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (xferOut && !xferIn) begin
            state_q <= ST_EMPTY;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
      if (xferIn) begin
        code_q   <= coreCode;
        onehot_q <= coreOnehot;
        zero_q   <= coreZero;
      end
      ptr_q <= ptr_d;
    end
  end

`ifdef ENC_ERR_CNT_EN
  logic [7:0] errCnt_q;
  logic [7:0] errCnt_d;

  // Every accepted vector that is not one-hot (zero or multi-hot) counts as
  // an error; the counter sticks at 255 rather than wrapping.
  always_comb begin
    errCnt_d = errCnt_q;
    if (xferIn && !coreOnehot && (errCnt_q != 8'hFF)) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  // Error counter register, cleared together with the rest of the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_encoder_nbits_pipe.sv
// ---------------------------------------------------------------------------
// tb_encoder_nbits_pipe
// Three instances share clock and reset: u0 WIDTH=8 fixed priority,
// u1 WIDTH=8 round-robin, u2 WIDTH=5 round-robin. A negedge monitor pushes a
// model result for every accepted vector and pops/compares it on every
// output transfer; directed steps add spot checks against literal values.
// ---------------------------------------------------------------------------
module tb_encoder_nbits_pipe;

  logic       clk;
  logic       reset;
  logic       inV  [3];
  logic       inR  [3];
  logic [7:0] inD  [3];
  logic       outV [3];
  logic       outR [3];
  logic [2:0] outC [3];
  logic       outOh[3];
  logic       outZ [3];
`ifdef ENC_ERR_CNT_EN
  logic [7:0] errC [3];
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         d;
    logic [2:0] code;
    logic       oh;
    logic       z;
    logic [7:0] err;
  } exp_t;

  exp_t sbq[$];
  int   mPtr[3];
  int   mErr[3];

  encoder_nbits_pipe #(.WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(inV[0]), .in_ready(inR[0]), .in_data(inD[0]),
    .out_valid(outV[0]), .out_ready(outR[0]),
    .out_code(outC[0]), .out_onehot(outOh[0]), .out_zero(outZ[0])
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(errC[0])
`endif
  );

  encoder_nbits_pipe #(.WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(inV[1]), .in_ready(inR[1]), .in_data(inD[1]),
    .out_valid(outV[1]), .out_ready(outR[1]),
    .out_code(outC[1]), .out_onehot(outOh[1]), .out_zero(outZ[1])
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(errC[1])
`endif
  );

  encoder_nbits_pipe #(.WIDTH(5), .MODE(1)) u2 (
    .clk(clk), .reset(reset),
    .in_valid(inV[2]), .in_ready(inR[2]), .in_data(inD[2][4:0]),
    .out_valid(outV[2]), .out_ready(outR[2]),
    .out_code(outC[2]), .out_onehot(outOh[2]), .out_zero(outZ[2])
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(errC[2])
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream of the bounded waits goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic valid, input logic [7:0] data,
                               input logic ready);
    inV[d]  = valid;
    inD[d]  = data;
    outR[d] = ready;
  endtask

  // Present one vector and hold it until it has been accepted.
  task automatic sendVec(input int d, input logic [7:0] data);
    int waited;
    waited = 0;
    inV[d] = 1'b1;
    inD[d] = data;
    while (!inR[d] && (waited < 50)) begin
      step(1);
      waited++;
    end
    checks++;
    assert (waited < 50) else begin
      failures++;
      $error("[TB] FAIL send_timeout dut=%0d observed=%0d expected=<50", d, waited);
    end
    step(1);
    inV[d] = 1'b0;
  endtask

  task automatic expectOut(input string tag, input int d, input int code,
                           input logic oh, input logic z);
    checkOutput({tag, "_valid"},  32'(outV[d]),  32'd1);
    checkOutput({tag, "_code"},   32'(outC[d]),  32'(code));
    checkOutput({tag, "_onehot"}, 32'(outOh[d]), 32'(oh));
    checkOutput({tag, "_zero"},   32'(outZ[d]),  32'(z));
  endtask

  function automatic int widthOf(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  // Reference behaviour: scan upward from the pointer (0 for the fixed
  // instance), count ones, advance the pointer and error count.
  function automatic exp_t modelOf(input int d, input logic [7:0] data);
    exp_t e;
    int   w;
    int   start;
    int   ones;
    int   idx;
    logic found;
    w      = widthOf(d);
    start  = (d == 0) ? 0 : mPtr[d];
    e.d    = d;
    e.code = '0;
    found  = 1'b0;
    ones   = 0;
    for (int k = 0; k < w; k++) begin
      if (data[k[2:0]]) ones++;
      idx = (start + k) % w;
      if (!found && data[idx[2:0]]) begin
        found  = 1'b1;
        e.code = 3'(idx);
      end
    end
    e.oh = (ones == 1);
    e.z  = (ones == 0);
    if ((d != 0) && found) mPtr[d] = (int'(e.code) + 1) % w;
    if ((ones != 1) && (mErr[d] < 255)) mErr[d]++;
    e.err = 8'(mErr[d]);
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle. Reset discards everything in
  // flight; otherwise an output transfer pops the oldest entry of that
  // instance and an input transfer pushes a fresh model result.
  always @(negedge clk) begin
    int hit;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        checkOutput("in_ready_during_reset", 32'(inR[d]), 32'd1);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
          if (sbq[i].d == d) sbq.delete(i);
        end
        mPtr[d] = 0;
        mErr[d] = 0;
      end else begin
        if (outV[d] && outR[d]) begin
          hit = -1;
          for (int i = 0; i < sbq.size(); i++) begin
            if ((hit < 0) && (sbq[i].d == d)) hit = i;
          end
          checks++;
          assert (hit >= 0) else begin
            failures++;
            $error("[TB] FAIL sb_unexpected_output dut=%0d observed=%0h expected=none", d, outC[d]);
          end
          if (hit >= 0) begin
            checkOutput("sb_code",   32'(outC[d]),  32'(sbq[hit].code));
            checkOutput("sb_onehot", 32'(outOh[d]), 32'(sbq[hit].oh));
            checkOutput("sb_zero",   32'(outZ[d]),  32'(sbq[hit].z));
`ifdef ENC_ERR_CNT_EN
            checkOutput("sb_err_cnt", 32'(errC[d]), 32'(sbq[hit].err));
`endif
            sbq.delete(hit);
          end
        end
        if (inV[d] && inR[d]) begin
          sbq.push_back(modelOf(d, inD[d]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, 1'b0, 8'h00, 1'b1);
    end
    step(2);
    reset = 1'b0;

    // Reset state of every instance
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_valid",  32'(outV[d]),  32'd0);
      checkOutput("rst_code",   32'(outC[d]),  32'd0);
      checkOutput("rst_onehot", 32'(outOh[d]), 32'd0);
      checkOutput("rst_zero",   32'(outZ[d]),  32'd0);
`ifdef ENC_ERR_CNT_EN
      checkOutput("rst_err_cnt", 32'(errC[d]), 32'd0);
`endif
    end

    // Fixed priority: one-hot, multi-hot, zero
    sendVec(0, 8'h10);
    expectOut("fix_onehot", 0, 4, 1'b1, 1'b0);
`ifdef ENC_ERR_CNT_EN
    checkOutput("fix_onehot_err", 32'(errC[0]), 32'd0);
`endif
    sendVec(0, 8'hA0);
    expectOut("fix_multihot", 0, 5, 1'b0, 1'b0);
`ifdef ENC_ERR_CNT_EN
    checkOutput("fix_multihot_err", 32'(errC[0]), 32'd1);
`endif
    sendVec(0, 8'h00);
    expectOut("fix_zero", 0, 0, 1'b0, 1'b1);
`ifdef ENC_ERR_CNT_EN
    checkOutput("fix_zero_err", 32'(errC[0]), 32'd2);
`endif
    step(1);

    // Round-robin, WIDTH=8 and non-power-of-2 WIDTH=5 wrap
    sendVec(1, 8'h81);
    checkOutput("rr8_first", 32'(outC[1]), 32'd0);
    sendVec(1, 8'h81);
    checkOutput("rr8_second", 32'(outC[1]), 32'd7);
    sendVec(1, 8'h81);
    checkOutput("rr8_third", 32'(outC[1]), 32'd0);
    sendVec(2, 8'h11);
    checkOutput("rr5_first", 32'(outC[2]), 32'd0);
    sendVec(2, 8'h11);
    checkOutput("rr5_second", 32'(outC[2]), 32'd4);
    sendVec(2, 8'h11);
    checkOutput("rr5_third", 32'(outC[2]), 32'd0);
    step(1);

    // Backpressure: second vector waits while the first is held
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    sendVec(0, 8'h02);
    applyStimulus(0, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      expectOut("bp_hold", 0, 1, 1'b1, 1'b0);
      checkOutput("bp_in_ready", 32'(inR[0]), 32'd0);
    end
    applyStimulus(0, 1'b1, 8'h40, 1'b1);
    step(1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    expectOut("bp_next", 0, 6, 1'b1, 1'b0);
    step(1);
    expectOut("bp_next_held", 0, 6, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    step(2);

    // Streaming: one result per cycle with no bubbles
    applyStimulus(0, 1'b1, 8'h01, 1'b1);
    step(1);
    expectOut("stream_0", 0, 0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 8'h02, 1'b1);
    step(1);
    expectOut("stream_1", 0, 1, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 8'h04, 1'b1);
    step(1);
    expectOut("stream_2", 0, 2, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    step(2);

    // Reset mid-operation: u1 FULL and stalled with ptr=3, err_cnt=5
    sendVec(1, 8'h00);
    sendVec(1, 8'h0C);
    outR[1] = 1'b0;
    expectOut("pre_reset", 1, 2, 1'b0, 1'b0);
`ifdef ENC_ERR_CNT_EN
    checkOutput("pre_reset_err", 32'(errC[1]), 32'd5);
`endif
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("post_reset_valid", 32'(outV[1]), 32'd0);
    checkOutput("post_reset_code",  32'(outC[1]), 32'd0);
`ifdef ENC_ERR_CNT_EN
    checkOutput("post_reset_err", 32'(errC[1]), 32'd0);
`endif
    outR[1] = 1'b1;
    sendVec(1, 8'h88);
    checkOutput("post_reset_rr", 32'(outC[1]), 32'd3);
    step(1);

    // Pointer is now 4; a reset must bring it back to 0
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    sendVec(1, 8'h81);
    checkOutput("ptr_cleared", 32'(outC[1]), 32'd0);

    // Everything pushed must have been popped exactly once
    for (int d = 0; d < 3; d++) outR[d] = 1'b1;
    step(3);
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
